// File: rtl/unpool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : unpool_pkg                                               |
// | Purpose   : Shared types and constants for the 2x2 max-unpool stage  |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package unpool_pkg;

  // Output-sequencing states: top-left column, top-right column, bottom row replay.
  typedef enum logic [1:0] {
    TOP_L = 2'd0,
    TOP_R = 2'd1,
    BOT   = 2'd2
  } state_e;

  // Argmax position inside the 2x2 window.
  localparam logic [1:0] IDX_TL = 2'd0;
  localparam logic [1:0] IDX_TR = 2'd1;
  localparam logic [1:0] IDX_BL = 2'd2;
  localparam logic [1:0] IDX_BR = 2'd3;

  // Operating modes.
  localparam int MODE_REPL = 0;
  localparam int MODE_MAX  = 1;

  // Counter width able to address n distinct values, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unpool_row_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : unpool_row_buf                                           |
// | Purpose   : One pooled row of {data, idx} entries; sync write,       |
// |             combinational read, contents deliberately not reset      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module unpool_row_buf #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 18,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Capture each accepted pooled sample at its column slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/max_unpool2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : max_unpool2                                              |
// | Purpose   : Streaming 2x2 max-unpooling decoder; one pooled value in,|
// |             four raster-ordered output samples out                   |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module max_unpool2
  import unpool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int POOL_W     = 8,
  parameter int POOL_H     = 8,
  parameter int MODE       = MODE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_eol,
  output logic                  out_last
);

  localparam int COL_W  = cnt_width(POOL_W);
  localparam int BCOL_W = cnt_width(2 * POOL_W);
  localparam int ROW_W  = cnt_width(POOL_H);
  localparam int ENT_W  = DATA_WIDTH + 2;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(POOL_W - 1);
  localparam logic [BCOL_W-1:0] BCOL_LAST = BCOL_W'(2 * POOL_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(POOL_H - 1);
  localparam bit                REPLICATE = (MODE == MODE_REPL);

  state_e                  state_q;
  logic [COL_W-1:0]        col_q;
  logic [BCOL_W-1:0]       bcol_q;
  logic [ROW_W-1:0]        row_q;
  logic [DATA_WIDTH-1:0]   hold_data_q;
  logic [1:0]              hold_idx_q;
  logic                    out_valid_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_eol_q;
  logic                    out_last_q;

  logic                    advance;
  logic                    accept;
  logic [COL_W-1:0]        rd_addr;
  logic [ENT_W-1:0]        rd_entry;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [1:0]              rd_idx;
  logic [1:0]              bot_sel;
  logic                    top_l_keep;
  logic                    top_r_keep;
  logic                    bot_keep;

  // The output register may load whenever it is empty or being drained.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = (state_q == TOP_L) && advance && !rst;
  assign accept   = in_valid && in_ready;

  // Bottom row replays each buffered entry twice (even then odd column).
  assign rd_addr  = COL_W'(bcol_q >> 1);
  assign rd_data  = rd_entry[ENT_W-1:2];
  assign rd_idx   = rd_entry[1:0];
  assign bot_sel  = bcol_q[0] ? IDX_BR : IDX_BL;

  // Replicate mode passes the value to every position of the window.
  assign top_l_keep = REPLICATE || (in_idx == IDX_TL);
  assign top_r_keep = REPLICATE || (hold_idx_q == IDX_TR);
  assign bot_keep   = REPLICATE || (rd_idx == bot_sel);

  unpool_row_buf #(
    .DEPTH  (POOL_W),
    .WIDTH  (ENT_W),
    .ADDR_W (COL_W)
  ) u_row_buf (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i ({in_data, in_idx}),
    .raddr_i (rd_addr),
    .rdata_o (rd_entry)
  );

  // Sequencer and registered output beat; nothing moves unless the beat advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TOP_L;
      col_q       <= '0;
      bcol_q      <= '0;
      row_q       <= '0;
      hold_data_q <= '0;
      hold_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        TOP_L: begin
          if (advance) begin
            out_eol_q  <= 1'b0;
            out_last_q <= 1'b0;
            if (accept) begin
              hold_data_q <= in_data;
              hold_idx_q  <= in_idx;
              out_valid_q <= 1'b1;
              out_data_q  <= top_l_keep ? in_data : '0;
              state_q     <= TOP_R;
            end else begin
              // Starved: drop the beat rather than repeat the previous sample.
              out_valid_q <= 1'b0;
            end
          end
        end

        TOP_R: begin
          if (advance) begin
            out_valid_q <= 1'b1;
            out_data_q  <= top_r_keep ? hold_data_q : '0;
            out_last_q  <= 1'b0;
            if (col_q == COL_LAST) begin
              out_eol_q <= 1'b1;
              col_q     <= '0;
              bcol_q    <= '0;
              state_q   <= BOT;
            end else begin
              out_eol_q <= 1'b0;
              col_q     <= col_q + COL_W'(1);
              state_q   <= TOP_L;
            end
          end
        end

        BOT: begin
          if (advance) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bot_keep ? rd_data : '0;
            if (bcol_q == BCOL_LAST) begin
              out_eol_q  <= 1'b1;
              out_last_q <= (row_q == ROW_LAST);
              row_q      <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
              bcol_q     <= '0;
              state_q    <= TOP_L;
            end else begin
              out_eol_q  <= 1'b0;
              out_last_q <= 1'b0;
              bcol_q     <= bcol_q + BCOL_W'(1);
            end
          end
        end

        default: begin
          state_q <= TOP_L;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eol   = out_eol_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_max_unpool2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_max_unpool2                                           |
// | Purpose   : Self-checking bench for max_unpool2 against a raster     |
// |             model of the upsampled frame                             |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_max_unpool2;

  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic          eol;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Three instances: [0] max 2x1, [1] replicate 2x1, [2] max 4x4.
  logic [2:0]    in_valid, in_ready, out_valid, out_ready, out_eol, out_last;
  logic [DW-1:0] in_data  [3];
  logic [1:0]    in_idx   [3];
  logic [DW-1:0] out_data [3];

  int cfg_w [3] = '{2, 2, 4};
  int cfg_h [3] = '{1, 1, 4};
  int cfg_m [3] = '{1, 0, 1};

  max_unpool2 #(.DATA_WIDTH(DW), .POOL_W(2), .POOL_H(1), .MODE(1)) u_max_small (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_idx(in_idx[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_eol(out_eol[0]),
    .out_last(out_last[0]));

  max_unpool2 #(.DATA_WIDTH(DW), .POOL_W(2), .POOL_H(1), .MODE(0)) u_repl_small (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_idx(in_idx[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_eol(out_eol[1]),
    .out_last(out_last[1]));

  max_unpool2 #(.DATA_WIDTH(DW), .POOL_W(4), .POOL_H(4), .MODE(1)) u_max_big (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_idx(in_idx[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_eol(out_eol[2]),
    .out_last(out_last[2]));

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] stim_d [$];
  logic [1:0]    stim_i [$];
  beat_t         exp_q  [$];
  beat_t         got_q  [$];
  int            acc_cyc [$];
  int            first_val, low_cnt, hold_viol, rdy_viol, timed_out;

  // Reference: each pooled row becomes a top row then a bottom row of 2*W samples.
  function automatic void build_exp(input int k);
    int w, h, g, c, r;
    logic [DW-1:0] d;
    logic [1:0] ix;
    bit repl;
    beat_t b;
    w = cfg_w[k]; h = cfg_h[k]; repl = (cfg_m[k] == 0);
    exp_q.delete();
    for (g = 0; g < stim_d.size() / w; g++) begin
      r = g % h;
      for (c = 0; c < w; c++) begin
        d = stim_d[g*w+c]; ix = stim_i[g*w+c];
        b.d = (repl || ix == 2'd0) ? d : '0; b.eol = 1'b0; b.last = 1'b0; exp_q.push_back(b);
        b.d = (repl || ix == 2'd1) ? d : '0; b.eol = (c == w-1); exp_q.push_back(b);
      end
      for (c = 0; c < w; c++) begin
        d = stim_d[g*w+c]; ix = stim_i[g*w+c];
        b.d = (repl || ix == 2'd2) ? d : '0; b.eol = 1'b0; b.last = 1'b0; exp_q.push_back(b);
        b.d = (repl || ix == 2'd3) ? d : '0; b.eol = (c == w-1);
        b.last = (c == w-1) && (r == h-1); exp_q.push_back(b);
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0; out_ready = '1;
    for (int i = 0; i < 3; i++) begin in_data[i] = '0; in_idx[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic new_stim(input int n, input bit rnd_idx);
    stim_d.delete(); stim_i.delete();
    for (int i = 0; i < n; i++) begin
      stim_d.push_back(DW'($urandom));
      stim_i.push_back(rnd_idx ? 2'($urandom_range(3)) : 2'd0);
    end
  endtask

  // Drive stim on instance k, collect handshaken beats and record protocol violations.
  task automatic run_stream(input int k, input int gap, input int bp_pct, input int stop_beats);
    int ptr, acc, took, wait_c, cyc, budget, w, exp_loaded;
    bit pv, pr, done;
    beat_t pb, b;
    w = cfg_w[k]; ptr = 0; acc = 0; took = 0; wait_c = 0; cyc = 0;
    budget = 2000 + stim_d.size() * (gap + 10) * 4;
    got_q.delete(); acc_cyc.delete();
    first_val = -1; low_cnt = 0; hold_viol = 0; rdy_viol = 0; timed_out = 0; pv = 0; pr = 0;
    pb.d = '0; pb.eol = 1'b0; pb.last = 1'b0;
    in_valid[k] = (stim_d.size() > 0);
    if (stim_d.size() > 0) begin in_data[k] = stim_d[0]; in_idx[k] = stim_i[0]; end
    out_ready[k] = ($urandom_range(99) >= bp_pct);
    while (1) begin
      @(negedge clk);
      if (pv && !pr) begin
        if (!(out_valid[k] && out_data[k] === pb.d && out_eol[k] === pb.eol && out_last[k] === pb.last)) begin
          if (hold_viol == 0)
            $display("  hold violation k=%0d cyc=%0d: v=%b d=%h eol=%b last=%b, held d=%h eol=%b last=%b",
                     k, cyc, out_valid[k], out_data[k], out_eol[k], out_last[k], pb.d, pb.eol, pb.last);
          hold_viol++;
        end
      end
      if (in_ready[k]) begin
        exp_loaded = 4*w*(acc/w) + 2*(acc%w);
        if (took + int'(out_valid[k]) != exp_loaded) rdy_viol++;
      end
      if (!out_valid[k]) low_cnt++;
      else if (first_val < 0) first_val = cyc;
      if (in_valid[k] && in_ready[k]) begin
        acc++; ptr++; wait_c = gap; acc_cyc.push_back(cyc);
      end
      if (out_valid[k] && out_ready[k]) begin
        b.d = out_data[k]; b.eol = out_eol[k]; b.last = out_last[k];
        got_q.push_back(b); took++;
      end
      pv = out_valid[k]; pr = out_ready[k];
      pb.d = out_data[k]; pb.eol = out_eol[k]; pb.last = out_last[k];
      cyc++;
      done = (stop_beats > 0) ? (took >= stop_beats) : (took >= exp_q.size());
      @(posedge clk); #1;
      if (done) break;
      if (cyc > budget) begin timed_out = 1; break; end
      if (wait_c > 0) begin
        wait_c--; in_valid[k] = 1'b0;
      end else if (ptr < stim_d.size()) begin
        in_valid[k] = 1'b1; in_data[k] = stim_d[ptr]; in_idx[k] = stim_i[ptr];
      end else begin
        in_valid[k] = 1'b0;
      end
      out_ready[k] = ($urandom_range(99) >= bp_pct);
    end
    in_valid[k] = 1'b0; out_ready[k] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '1; out_ready = '1;
    for (int i = 0; i < 3; i++) begin in_data[i] = 16'hBEEF; in_idx[i] = 2'd0; end
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid[k], out_eol[k], out_last[k], in_ready[k], out_data[k]} !== '0) begin
        errors++;
        $display("FAIL reset k=%0d: v=%b eol=%b last=%b rdy=%b d=%h, required all 0",
                 k, out_valid[k], out_eol[k], out_last[k], in_ready[k], out_data[k]);
      end
    end
  endtask

  task automatic test_max_basic();
    int ed [8] = '{5, 0, 0, 0, 0, 0, 0, 9};
    do_reset();
    stim_d.delete(); stim_i.delete();
    stim_d.push_back(16'd5); stim_i.push_back(2'd0);
    stim_d.push_back(16'd9); stim_i.push_back(2'd3);
    build_exp(0);
    run_stream(0, 0, 0, 0);
    checks++;
    if (got_q.size() != 8 || timed_out != 0) begin
      errors++; $display("FAIL max_basic_count: got %0d beats timeout=%0d, required 8 beats", got_q.size(), timed_out);
    end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      checks++;
      if (got_q[i].d !== DW'(ed[i]) || got_q[i].eol !== (i == 3 || i == 7) || got_q[i].last !== (i == 7)) begin
        errors++;
        $display("FAIL max_basic beat %0d: d=%0d eol=%b last=%b, required d=%0d eol=%b last=%b",
                 i, got_q[i].d, got_q[i].eol, got_q[i].last, ed[i], (i == 3 || i == 7), (i == 7));
      end
    end
    checks++;
    if (acc_cyc.size() < 1 || first_val - acc_cyc[0] != 1) begin
      errors++; $display("FAIL latency: first output %0d cycles after accept, required 1",
                         acc_cyc.size() > 0 ? first_val - acc_cyc[0] : -1);
    end
    checks++;
    if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] != 2) begin
      errors++; $display("FAIL back_to_back: accept spacing %0d, required 2",
                         acc_cyc.size() > 1 ? acc_cyc[1] - acc_cyc[0] : -1);
    end
  endtask

  task automatic test_replicate();
    int ed [8] = '{7, 7, 3, 3, 7, 7, 3, 3};
    do_reset();
    stim_d.delete(); stim_i.delete();
    stim_d.push_back(16'd7); stim_i.push_back(2'($urandom_range(3)));
    stim_d.push_back(16'd3); stim_i.push_back(2'($urandom_range(3)));
    build_exp(1);
    run_stream(1, 0, 0, 0);
    checks++;
    if (got_q.size() != 8 || timed_out != 0) begin
      errors++; $display("FAIL repl_count: got %0d beats timeout=%0d, required 8 beats", got_q.size(), timed_out);
    end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      checks++;
      if (got_q[i].d !== DW'(ed[i]) || got_q[i].eol !== (i == 3 || i == 7) || got_q[i].last !== (i == 7)) begin
        errors++;
        $display("FAIL repl beat %0d: d=%0d eol=%b last=%b, required d=%0d eol=%b last=%b",
                 i, got_q[i].d, got_q[i].eol, got_q[i].last, ed[i], (i == 3 || i == 7), (i == 7));
      end
    end
  endtask

  task automatic test_frame_wrap();
    int nlast;
    do_reset();
    new_stim(2, 1'b1);
    stim_d.push_back(stim_d[0]); stim_i.push_back(stim_i[0]);
    stim_d.push_back(stim_d[1]); stim_i.push_back(stim_i[1]);
    build_exp(0);
    run_stream(0, 0, 0, 0);
    checks++;
    if (got_q.size() != exp_q.size() || timed_out != 0) begin
      errors++; $display("FAIL wrap_count: got %0d beats timeout=%0d, required %0d", got_q.size(), timed_out, exp_q.size());
    end
    nlast = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i].last === 1'b1) nlast++;
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL wrap beat %0d: d=%h eol=%b last=%b, required d=%h eol=%b last=%b",
                 i, got_q[i].d, got_q[i].eol, got_q[i].last, exp_q[i].d, exp_q[i].eol, exp_q[i].last);
      end
    end
    checks++;
    if (nlast != 2) begin
      errors++; $display("FAIL wrap_last_count: %0d last beats, required 2", nlast);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    new_stim(16, 1'b1);
    build_exp(2);
    run_stream(2, 0, 50, 0);
    checks++;
    if (got_q.size() != exp_q.size() || timed_out != 0) begin
      errors++; $display("FAIL bp_count: got %0d beats timeout=%0d, required %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL bp beat %0d: d=%h eol=%b last=%b, required d=%h eol=%b last=%b",
                 i, got_q[i].d, got_q[i].eol, got_q[i].last, exp_q[i].d, exp_q[i].eol, exp_q[i].last);
      end
    end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: %0d stalled beats changed, required 0", hold_viol); end
    checks++;
    if (rdy_viol != 0) begin errors++; $display("FAIL bp_in_ready: %0d cycles ready mid-window, required 0", rdy_viol); end
  endtask

  task automatic test_starvation();
    do_reset();
    new_stim(16, 1'b1);
    build_exp(2);
    run_stream(2, 10, 0, 0);
    checks++;
    if (got_q.size() != exp_q.size() || timed_out != 0) begin
      errors++; $display("FAIL starve_count: got %0d beats timeout=%0d, required %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL starve beat %0d: d=%h eol=%b last=%b, required d=%h eol=%b last=%b",
                 i, got_q[i].d, got_q[i].eol, got_q[i].last, exp_q[i].d, exp_q[i].eol, exp_q[i].last);
      end
    end
    checks++;
    if (low_cnt < 16) begin errors++; $display("FAIL starve_gap: out_valid low %0d cycles, required at least 16", low_cnt); end
    checks++;
    if (rdy_viol != 0) begin errors++; $display("FAIL starve_in_ready: %0d bad ready cycles, required 0", rdy_viol); end
  endtask

  task automatic test_reset_mid_bot();
    do_reset();
    new_stim(16, 1'b1);
    build_exp(2);
    run_stream(2, 0, 0, 10);
    checks++;
    if (got_q.size() != 10 || timed_out != 0) begin
      errors++; $display("FAIL midbot_prefix_count: got %0d beats, required 10", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++; $display("FAIL midbot_prefix beat %0d: d=%h, required d=%h", i, got_q[i].d, exp_q[i].d);
      end
    end
    rst = 1'b1; in_valid[2] = 1'b1; in_data[2] = 16'h1234;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({out_valid[2], out_eol[2], out_last[2], in_ready[2], out_data[2]} !== '0) begin
      errors++;
      $display("FAIL midbot_reset: v=%b eol=%b last=%b rdy=%b d=%h, required all 0",
               out_valid[2], out_eol[2], out_last[2], in_ready[2], out_data[2]);
    end
    @(posedge clk); #1 rst = 1'b0; in_valid[2] = 1'b0;
    new_stim(16, 1'b1);
    build_exp(2);
    run_stream(2, 0, 30, 0);
    checks++;
    if (got_q.size() != exp_q.size() || timed_out != 0) begin
      errors++; $display("FAIL midbot_frame_count: got %0d beats timeout=%0d, required %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL midbot_frame beat %0d: d=%h eol=%b last=%b, required d=%h eol=%b last=%b",
                 i, got_q[i].d, got_q[i].eol, got_q[i].last, exp_q[i].d, exp_q[i].eol, exp_q[i].last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_max_basic();
    test_replicate();
    test_frame_wrap();
    test_backpressure();
    test_starvation();
    test_reset_mid_bot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/max_unpool2.md
# max_unpool2

Streaming 2x2 max-unpooling decoder. It is the inverse of the pooling comparator stage. It accepts one pooled value per beat with a 2-bit argmax index and emits the 2x-upsampled feature map in raster order. The winning position carries the value and the other three positions carry zero; in replicate mode the value goes to all four. It sits on the decoder/upsampling path of the accelerator, between the feature-map buffer and the next convolution stage.

## Interface
- `DATA_WIDTH`, 16: width of the pooled and unpooled samples.
- `POOL_W`, 8: pooled row width; output rows are `2*POOL_W` wide.
- `POOL_H`, 8: pooled rows per frame; a frame has `2*POOL_H` output rows.
- `MODE`, 1: 1 = max-unpool using the index; 0 = nearest replicate, index ignored.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts the input beat this cycle.
- `in_data` in `DATA_WIDTH`: pooled value.
- `in_idx` in 2: argmax position: 0 = top-left, 1 = top-right, 2 = bottom-left, 3 = bottom-right.
- `out_valid` out 1: output beat valid (registered).
- `out_ready` in 1: downstream accepts the output beat.
- `out_data` out `DATA_WIDTH`: unpooled sample (registered).
- `out_eol` out 1: last sample of an output row.
- `out_last` out 1: last sample of the frame, at row `2*POOL_H-1`, column `2*POOL_W-1`.

## Operation
- FSM states:
  - `TOP_L`: waits for input; emits the even column of the top output row.
  - `TOP_R`: emits the odd column of the top output row.
  - `BOT`: replays the row buffer as the bottom output row.
- Row buffer: `POOL_W` entries of {data, idx}, written in `TOP_L` at the accepted column `col`.
- An output beat "advances" when `!out_valid || out_ready`. The output register loads only on advance.
- `TOP_L`: `in_ready = advance && !rst`. On accept:
  - Store {in_data, in_idx} in the hold register and in `buf[col]`.
  - Load `out_data` = (idx==0 || MODE==0) ? data : 0.
  - Go to `TOP_R`.
- `TOP_R`: on advance, load `out_data` from the hold register = (idx==1 || MODE==0) ? data : 0.
  - If `col == POOL_W-1`: assert `out_eol`, clear `col`, go to `BOT` with `bcol = 0`.
  - Else: increment `col`, go to `TOP_L`.
- `BOT`: on advance, read `buf[bcol>>1]`.
  - Even `bcol` selects idx==2; odd `bcol` selects idx==3. MODE 0 always passes the value.
  - `bcol == 2*POOL_W-1` asserts `out_eol`. It also asserts `out_last` if `row == POOL_H-1`.
  - On that last beat: `row` wraps to 0 if it was the last row, else increments. Go to `TOP_L`.
- `in_ready` is 0 in `TOP_R` and `BOT`. An input that is held valid waits without loss.
- Output beats hold stable while `out_valid && !out_ready`; `out_data`, `out_eol` and `out_last` must not change.
- If the FSM has nothing to load on advance (`TOP_L` with no input), `out_valid` deasserts.
- `out_eol` and `out_last` are 0 on every other beat.

## Timing
- Reset values:
  - Outputs: `out_valid` 0, `out_data` 0, `out_eol` 0, `out_last` 0, `in_ready` 0 while `rst` is high.
  - Internal: state `TOP_L`; `col`, `bcol`, `row` = 0.
- Latency: an accepted input appears on `out_data` in the next cycle, as the top-left sample.
- Throughput with `out_ready` tied high: one output per cycle and exactly 4 output beats per input.
  - Each pooled row takes `4*POOL_W` cycles: `2*POOL_W` top, then `2*POOL_W` bottom.
  - Input duty cycle is 25%.
- Back-to-back inputs in the top row are accepted every 2 cycles.
- Reset mid-row or mid-`BOT` discards the partial row and buffer contents. The next accepted input is treated as column 0, row 0.
- Simultaneous `in_valid` and downstream stall in `TOP_L`: the input is not accepted and nothing changes.

## Structure
- Shared package `unpool_pkg`:
  - State enum `{TOP_L, TOP_R, BOT}`.
  - Index constants `IDX_TL=0`, `IDX_TR=1`, `IDX_BL=2`, `IDX_BR=3`.
  - Mode constants `MODE_REPL=0`, `MODE_MAX=1`.
- One sub-module: `unpool_row_buf`, a `POOL_W`-deep, (`DATA_WIDTH+2`)-wide register array.
  - One synchronous write port, one combinational read port.
  - No reset on contents.
- Counter widths: `$clog2` of each bound, with a minimum of 1.

## Test plan
- **MODE 1, POOL_W=2, POOL_H=1:** inputs (5,idx0), (9,idx3) with ready high.
  - Output rows must be `5,0,0,0` then `0,0,0,9`.
  - `out_eol` on beats 4 and 8; `out_last` on beat 8 only.
- **MODE 0, same geometry:** inputs 7 and 3.
  - Output rows must be `7,7,3,3` / `7,7,3,3`.
- **Backpressure:** toggle `out_ready` pseudo-randomly for a 4x4 pooled frame.
  - The output sequence must match the golden model.
  - No beat changes while stalled.
  - `in_ready` is never high in `TOP_R` or `BOT`.
- **Input starvation:** leave a 10-cycle gap between inputs.
  - `out_valid` drops after `TOP_R`; the stream resumes correctly.
- **Reset mid-`BOT`:** assert `rst` during the bottom row.
  - All outputs return to 0 next cycle.
  - The following frame starts at row 0, col 0 with a correct `out_last` position.
- **Frame wrap:** two consecutive frames.
  - `out_last` appears exactly once per frame.
  - The second frame is identical to the first for identical input.
